// File: rtl/serial_subtractor.sv
// Multi-cycle unsigned subtractor: diff = a - b - borrow_in, SLICE bits per clock, LSB first.
// Define SERIAL_SUB_SAT_EN to clamp underflowing results to zero.
module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int SLICE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] sa, sb;
    logic             borrow;
    logic [CW-1:0]    cnt;

    logic [SLICE-1:0]       d_s;
    logic                   bnext;
    logic [WIDTH+SLICE-1:0] wide;
    logic [WIDTH-1:0]       diff_nx;
    logic                   last;

    // Ripple the borrow through the low slice, one full-subtractor cell per bit.
    always_comb begin
        logic z;
        d_s = '0;
        z   = borrow;
        for (int unsigned i = 0; i < SLICE; i++) begin
            d_s[i] = sa[i] ^ sb[i] ^ z;
            z      = (~sa[i] & sb[i]) | (~sa[i] & z) | (sb[i] & z);
        end
        bnext = z;
    end

    // Concatenate then slice so the shift also works when SLICE == WIDTH.
    assign wide    = {d_s, diff};
    assign diff_nx = wide[WIDTH+SLICE-1:SLICE];
    assign last    = (cnt == CW'(NSLICE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            zero       <= 1'b1;
            cnt        <= '0;
            borrow     <= 1'b0;
            sa         <= '0;
            sb         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        sa       <= a;
                        sb       <= b;
                        borrow   <= borrow_in;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sa     <= sa >> SLICE;
                    sb     <= sb >> SLICE;
                    diff   <= diff_nx;
                    borrow <= bnext;
                    cnt    <= cnt + 1'b1;
                    if (last) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        borrow_out <= bnext;
`ifdef SERIAL_SUB_SAT_EN
                        if (bnext) begin
                            diff <= '0;
                            zero <= 1'b1;
                        end else begin
                            zero <= (diff_nx == '0);
                        end
`else
                        zero <= (diff_nx == '0);
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: an 8/1 instance and an 8/4 instance sharing operands.
module tb_serial_subtractor;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a, b;
    logic       borrow_in;
    logic       in_valid, out_ready, in_valid4, out_ready4;
    logic       in_ready, out_valid, borrow_out, zero;
    logic       in_ready4, out_valid4, borrow_out4, zero4;
    logic [7:0] diff, diff4;
    int         checks = 0;
    int         errors = 0;
    int         lat;
    logic [7:0] held;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8), .SLICE(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid),
        .out_ready(out_ready), .diff(diff), .borrow_out(borrow_out), .zero(zero)
    );

    serial_subtractor #(.WIDTH(8), .SLICE(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a), .b(b), .borrow_in(borrow_in), .out_valid(out_valid4),
        .out_ready(out_ready4), .diff(diff4), .borrow_out(borrow_out4), .zero(zero4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one operand set to the 8/1 instance and wait (bounded) for out_valid.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        @(negedge clk);
        a = av; b = bv; borrow_in = bi; in_valid = 1'b1;
        check("accept_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("busy_ready", in_ready, 0);
        check("busy_valid", out_valid, 0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("hs_valid", out_valid, 0);
        check("hs_ready", in_ready, 1);
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; borrow_in = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        check("rst_diff", diff, 0);
        check("rst_bo", borrow_out, 0);
        check("rst_zero", zero, 1);

        start_op(8'd100, 8'd37, 1'b0);
        check("t1_lat", lat, 8);
        check("t1_diff", diff, 63);
        check("t1_bo", borrow_out, 0);
        check("t1_zero", zero, 0);
        handshake();

        start_op(8'd5, 8'd9, 1'b0);
        check("t2_lat", lat, 8);
`ifdef SERIAL_SUB_SAT_EN
        check("t2_diff", diff, 8'h00);
        check("t2_zero", zero, 1);
`else
        check("t2_diff", diff, 8'hFC);
        check("t2_zero", zero, 0);
`endif
        check("t2_bo", borrow_out, 1);
        handshake();

        start_op(8'd0, 8'd0, 1'b1);
`ifdef SERIAL_SUB_SAT_EN
        check("t3_diff", diff, 8'h00);
        check("t3_zero", zero, 1);
`else
        check("t3_diff", diff, 8'hFF);
        check("t3_zero", zero, 0);
`endif
        check("t3_bo", borrow_out, 1);
        handshake();

        start_op(8'h2A, 8'h2A, 1'b0);
        check("t4_diff", diff, 0);
        check("t4_zero", zero, 1);
        check("t4_bo", borrow_out, 0);

        // Backpressure: result held while new operands are offered and refused.
        held = diff;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            a = a + 8'd17;
            check("bp_valid", out_valid, 1);
            check("bp_ready", in_ready, 0);
            check("bp_diff", diff, held);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_diff_end", diff, held);
        handshake();

        // Accept resumes immediately after the handshake.
        start_op(8'd50, 8'd20, 1'b1);
        check("t5_lat", lat, 8);
        check("t5_diff", diff, 29);
        handshake();

        // Slice width 4 on the second instance.
        @(negedge clk);
        a = 8'hA5; b = 8'h5A; borrow_in = 1'b0; in_valid4 = 1'b1;
        check("s4_ready", in_ready4, 1);
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        lat = 0;
        while (!out_valid4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("s4_lat", lat, 2);
        check("s4_diff", diff4, 8'h4B);
        check("s4_bo", borrow_out4, 0);
        check("s4_zero", zero4, 0);
        @(negedge clk);
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
        check("s4_hs_valid", out_valid4, 0);

        // Reset during the fourth RUN cycle aborts the operation.
        @(negedge clk);
        a = 8'd100; b = 8'd37; borrow_in = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("ab_valid", out_valid, 0);
        check("ab_ready", in_ready, 1);
        check("ab_diff", diff, 0);
        check("ab_zero", zero, 1);
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) lat++;
        end
        check("ab_no_pulse", lat, 0);

        start_op(8'd200, 8'd1, 1'b0);
        check("t6_lat", lat, 8);
        check("t6_diff", diff, 199);
        check("t6_bo", borrow_out, 0);
        handshake();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle, parametrised unsigned subtractor computing A - B - Bin over WIDTH bits, processing SLICE bits per clock, LSB slice first, with a ripple borrow held in a flip-flop between slices.
- Successor to the single-bit full subtractor: the same borrow equations, generalised in width and slice size, with valid/ready handshakes on both sides.
- Sits between an arithmetic front end and a result consumer where area matters more than throughput.

Parameters:
WIDTH, 8, operand and result width in bits; must be a multiple of SLICE.
SLICE, 1, bits subtracted per clock; NSLICE = WIDTH/SLICE cycles per operation.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
a  input  WIDTH  minuend
b  input  WIDTH  subtrahend
borrow_in  input  1  initial borrow
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
diff  output  WIDTH  result, (a - b - borrow_in) mod 2^WIDTH
borrow_out  output  1  final borrow out of the MSB; 1 iff a < b + borrow_in
zero  output  1  diff == 0

Behaviour:
- Single clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: state IDLE, in_ready=1, out_valid=0, diff=0, borrow_out=0, zero=1, slice counter=0, internal borrow=0.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a and b into shift registers and borrow_in into the borrow flop; counter=0; go to RUN.
  - in_ready is a registered function of state only; it does not depend combinationally on in_valid.
- RUN:
  - in_ready=0; inputs are ignored.
  - Each cycle computes {bnext, d} = a_slice - b_slice - borrow on the low SLICE bits.
  - Per bit: d = x^y^z; b = ~x&y | ~x&z | y&z.
  - Shift d into diff from the top; shift a and b right by SLICE.
  - Update borrow to bnext; increment counter.
  - When counter == NSLICE-1, go to DONE on that edge.
- Latency:
  - out_valid rises exactly NSLICE cycles after the accepting edge.
  - Minimum initiation interval is NSLICE+2 cycles when out_ready is held high.
- DONE:
  - out_valid=1. diff, borrow_out and zero stay stable until the handshake completes.
  - On out_ready: go to IDLE; out_valid=0 next cycle.
  - No new operand is accepted in the same cycle as the output handshake.
  - in_ready=0 while out_ready is held low, for an unbounded time.
- Wrap-around: the result is modulo 2^WIDTH. borrow_out=1 signals an underflow.
- Boundaries:
  - a=b with borrow_in=1 gives all-ones, borrow_out=1.
  - a=0, b=0, borrow_in=0 gives zero=1, borrow_out=0.
- Reset mid-operation: the current operation is aborted and its result discarded; all outputs return to reset values on the next edge. out_valid never pulses for an aborted operation.
- Intermediate diff contents during RUN are undefined to the consumer; they may be observed only while out_valid=1.

Optional Feature:
- Macro: SERIAL_SUB_SAT_EN.
- Defined: unsigned saturation. When the final borrow is 1, diff is forced to 0 and zero=1 on entry to DONE. borrow_out still reports 1.
- Undefined: diff wraps modulo 2^WIDTH as specified above.
- Handshake and latency are identical in both builds.

Test Plan:
- WIDTH=8, SLICE=1; a=100, b=37, borrow_in=0 -> diff=63, borrow_out=0, zero=0; out_valid exactly 8 cycles after accept.
- WIDTH=8, SLICE=1; a=5, b=9, borrow_in=0 -> diff=8'hFC, borrow_out=1. With SERIAL_SUB_SAT_EN: diff=0, zero=1, borrow_out=1.
- WIDTH=8; a=0, b=0, borrow_in=1 -> diff=8'hFF, borrow_out=1. Then a=8'h2A, b=8'h2A, borrow_in=0 -> diff=0, zero=1, borrow_out=0.
- WIDTH=8, SLICE=4; a=8'hA5, b=8'h5A -> diff=8'h4B, borrow_out=0; out_valid 2 cycles after accept.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid and a -> diff stable, in_ready=0, the new operands are not accepted; accept resumes 1 cycle after out_ready=1.
- Assert rst during the 4th RUN cycle -> next cycle out_valid=0, in_ready=1, diff=0; the following operation 200-1 -> diff=199 with correct latency.
